// File: rtl/seg_pkg.sv
// Shared segment patterns and converter state encoding for the BCD display block.
package seg_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_seg_display_if.sv
// Request/result bundle between the game-state counters and the display converter.
interface bcd_seg_display_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  blank_lz;
  logic                  ready;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output start, bin_in, blank_lz,
    input  ready, done, ovf, bcd_out, seg_out
  );

  modport slave (
    input  start, bin_in, blank_lz,
    output ready, done, ovf, bcd_out, seg_out
  );
endinterface

// File: rtl/seg7_encode.sv
// Nibble to active-low seven-segment pattern; non-decimal nibbles show a dash.
module seg7_encode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Plain lookup, no blanking or overflow handling here
  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Iterative double-dabble binary-to-BCD converter with seven-segment output stage.
// One binary bit is consumed per clock; results appear with a one-cycle done pulse.
module bcd_seg_display
  import seg_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_seg_display_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Shift-add-3 step applied to one BCD nibble before the shift
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  state_t             state_q, state_d;
  logic               ready;
  logic               accept;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_sticky_q;
  logic               blz_q;
  logic [BIN_W-1:0]   sh_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_adj;
  logic [6:0]         enc_seg [DIGITS];
  logic [7*DIGITS-1:0] seg_d;
  logic               lead;
  logic               done_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   bcd_q;
  logic [7*DIGITS-1:0] seg_q;

  assign accept = ready && bus.start;

  // State register; reset abandons any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and ready decode
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.start) state_d = ST_CONV;
      end
      ST_CONV: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Add-3 correction on every nibble of the accumulator
  always_comb begin
    acc_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      acc_adj[4*k +: 4] = add3(acc_q[4*k +: 4]);
    end
  end

  // Bit counter, sticky overflow and latched blanking request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
      blz_q        <= 1'b0;
    end else if (accept) begin
      cnt_q        <= CNT_W'(BIN_W);
      ovf_sticky_q <= 1'b0;
      blz_q        <= bus.blank_lz;
    end else if (state_q == ST_CONV) begin
      cnt_q <= cnt_q - CNT_W'(1);
      // A one leaving the top nibble means the value needs more digits
      if (acc_adj[ACC_W-1]) ovf_sticky_q <= 1'b1;
    end
  end

  // Binary shift register and BCD accumulator (data path, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_q  <= bus.bin_in;
      acc_q <= '0;
    end else if (state_q == ST_CONV) begin
      sh_q  <= sh_q << 1;
      acc_q <= {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
        .nib (acc_q[4*g +: 4]),
        .seg (enc_seg[g])
      );
    end
  endgenerate

  // Leading-zero blanking, scanning from the most significant digit down
  always_comb begin
    seg_d = '1;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (blz_q && lead && (k != 0) && (acc_q[4*k +: 4] == 4'd0)) begin
        seg_d[7*k +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*k +: 7] = enc_seg[k];
        lead = 1'b0;
      end
    end
  end

  // Result registers, updated only in the load cycle and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      bcd_q  <= '0;
      seg_q  <= '1;
    end else begin
      done_q <= (state_q == ST_LOAD);
      if (state_q == ST_LOAD) begin
        ovf_q <= ovf_sticky_q;
        if (ovf_sticky_q) begin
          bcd_q <= '1;
          seg_q <= {DIGITS{SEG_DASH}};
        end else begin
          bcd_q <= acc_q;
          seg_q <= seg_d;
        end
      end
    end
  end

  assign bus.ready   = ready;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;
  assign bus.seg_out = seg_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: a 5-digit and a 3-digit instance share clock and reset.
module tb_bcd_seg_display;

  typedef struct {
    logic [63:0] bcd;
    logic [63:0] seg;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q5[$];
  exp_t q3[$];
  int   acc_log5[$];
  int   done_log5[$];
  int   n_acc5, n_acc3, n_drop5, dcnt5, dcnt3;

  bcd_seg_display_if #(.BIN_W(16), .DIGITS(5)) b5 ();
  bcd_seg_display_if #(.BIN_W(16), .DIGITS(3)) b3 ();

  bcd_seg_display #(.BIN_W(16), .DIGITS(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b5.slave)
  );

  bcd_seg_display #(.BIN_W(16), .DIGITS(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] segc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference: repeated division by ten, independent of double-dabble
  function automatic exp_t model(input int unsigned v, input int nd, input bit blz);
    exp_t        e;
    int unsigned t;
    int          d [10];
    int          msd;
    e.bcd = '0;
    e.seg = '0;
    e.acc = 0;
    t = v;
    for (int k = 0; k < nd; k++) begin
      d[k] = int'(t % 10);
      t    = t / 10;
    end
    e.ovf = (t != 0);
    msd = 0;
    for (int k = 0; k < nd; k++) if (d[k] != 0) msd = k;
    for (int k = 0; k < nd; k++) begin
      if (e.ovf) begin
        e.bcd[4*k +: 4] = 4'hF;
        e.seg[7*k +: 7] = 7'b0111111;
      end else begin
        e.bcd[4*k +: 4] = 4'(d[k]);
        e.seg[7*k +: 7] = (blz && k > msd) ? 7'b1111111 : segc(d[k]);
      end
    end
    return e;
  endfunction

  // Monitor for the 5-digit instance: compare on done, then record accepted starts
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b5.done) begin
        dcnt5++;
        done_log5.push_back(cyc);
        if (q5.size() > 0) begin
          e = q5.pop_front();
          check("d5_latency", 64'(cyc - e.acc), 64'd17);
          check("d5_bcd", 64'(b5.bcd_out), e.bcd);
          check("d5_seg", 64'(b5.seg_out), e.seg);
          check("d5_ovf", 64'(b5.ovf), 64'(e.ovf));
        end
      end
      if (b5.start && b5.ready) begin
        e     = model(32'(b5.bin_in), 5, b5.blank_lz);
        e.acc = cyc + 1;
        q5.push_back(e);
        acc_log5.push_back(cyc + 1);
        n_acc5++;
      end
    end
  end

  // Monitor for the 3-digit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b3.done) begin
        dcnt3++;
        if (q3.size() > 0) begin
          e = q3.pop_front();
          check("d3_latency", 64'(cyc - e.acc), 64'd17);
          check("d3_bcd", 64'(b3.bcd_out), e.bcd);
          check("d3_seg", 64'(b3.seg_out), e.seg);
          check("d3_ovf", 64'(b3.ovf), 64'(e.ovf));
        end
      end
      if (b3.start && b3.ready) begin
        e     = model(32'(b3.bin_in), 3, b3.blank_lz);
        e.acc = cyc + 1;
        q3.push_back(e);
        n_acc3++;
      end
    end
  end

  task automatic go5(input int unsigned v, input bit blz);
    @(posedge clk); #1;
    b5.start = 1'b1; b5.bin_in = v[15:0]; b5.blank_lz = blz;
    @(posedge clk); #1;
    b5.start = 1'b0; b5.bin_in = 16'($urandom); b5.blank_lz = ~blz;
    repeat (20) @(posedge clk);
  endtask

  task automatic go3(input int unsigned v, input bit blz);
    @(posedge clk); #1;
    b3.start = 1'b1; b3.bin_in = v[15:0]; b3.blank_lz = blz;
    @(posedge clk); #1;
    b3.start = 1'b0; b3.bin_in = 16'($urandom); b3.blank_lz = ~blz;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    int na, nd, dbefore;
    cyc = 0; checks = 0; failures = 0;
    n_acc5 = 0; n_acc3 = 0; n_drop5 = 0; dcnt5 = 0; dcnt3 = 0;
    rst_n = 1'b0;
    b5.start = 1'b0; b5.bin_in = '0; b5.blank_lz = 1'b0;
    b3.start = 1'b0; b3.bin_in = '0; b3.blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(b5.ready), 64'd1);
    check("rst_done", 64'(b5.done), 64'd0);
    check("rst_ovf", 64'(b5.ovf), 64'd0);
    check("rst_bcd", 64'(b5.bcd_out), 64'd0);
    check("rst_seg", 64'(b5.seg_out), 64'h7_FFFF_FFFF);
    check("rst_seg3", 64'(b3.seg_out), 64'h1F_FFFF);
    @(negedge clk) rst_n = 1'b1;

    go5(65535, 1'b0);
    check("tp_65535_bcd", 64'(b5.bcd_out), 64'h65535);
    check("tp_65535_d0", 64'(b5.seg_out[6:0]), 64'(7'b0010010));
    check("tp_65535_d4", 64'(b5.seg_out[34:28]), 64'(7'b0000010));

    go5(305, 1'b1);
    check("tp_305_seg", 64'(b5.seg_out),
          64'({7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000, 7'b0010010}));
    check("tp_305_bcd", 64'(b5.bcd_out), 64'h00305);

    go5(0, 1'b1);
    check("tp_0_seg", 64'(b5.seg_out),
          64'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));

    go5(10020, 1'b1);
    go5(7, 1'b0);
    go5(40960, 1'b1);

    // Start held high: 12 accepted, then 34 accepted in the first done cycle
    na = acc_log5.size();
    nd = done_log5.size();
    @(posedge clk); #1;
    b5.start = 1'b1; b5.bin_in = 16'd12; b5.blank_lz = 1'b0;
    @(posedge clk); #1;
    b5.bin_in = 16'd34;
    repeat (18) @(posedge clk);
    #1 b5.start = 1'b0;
    repeat (20) @(posedge clk);
    check("b2b_accepts", 64'(acc_log5.size() - na), 64'd2);
    check("b2b_dones", 64'(done_log5.size() - nd), 64'd2);
    if (acc_log5.size() >= na + 2 && done_log5.size() >= nd + 1)
      check("b2b_accept_in_done", 64'(acc_log5[na+1]), 64'(done_log5[nd] + 1));
    check("b2b_last_bcd", 64'(b5.bcd_out), 64'h00034);

    // Start pulse during conversion must be ignored
    dbefore = dcnt5;
    @(posedge clk); #1;
    b5.start = 1'b1; b5.bin_in = 16'd500; b5.blank_lz = 1'b0;
    @(posedge clk); #1;
    b5.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 b5.start = 1'b1; b5.bin_in = 16'd777;
    @(posedge clk); #1;
    b5.start = 1'b0;
    repeat (25) @(posedge clk);
    check("midconv_dones", 64'(dcnt5 - dbefore), 64'd1);
    check("midconv_bcd", 64'(b5.bcd_out), 64'h00500);

    // Reset during conversion: immediate idle, blank, no done
    @(posedge clk); #1;
    b5.start = 1'b1; b5.bin_in = 16'd9999; b5.blank_lz = 1'b0;
    @(posedge clk); #1;
    b5.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    n_drop5 += q5.size();
    q5.delete();
    dbefore = dcnt5;
    #1;
    check("mrst_ready", 64'(b5.ready), 64'd1);
    check("mrst_seg", 64'(b5.seg_out), 64'h7_FFFF_FFFF);
    check("mrst_bcd", 64'(b5.bcd_out), 64'd0);
    check("mrst_done", 64'(b5.done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) @(posedge clk);
    check("mrst_no_done", 64'(dcnt5), 64'(dbefore));
    go5(42, 1'b0);
    check("post_rst_42", 64'(b5.bcd_out), 64'h00042);

    // Three-digit instance: range limit and overflow
    go3(999, 1'b0);
    check("d3_999_seg", 64'(b3.seg_out), 64'({3{7'b0010000}}));
    check("d3_999_ovf", 64'(b3.ovf), 64'd0);
    go3(1000, 1'b0);
    check("d3_1000_ovf", 64'(b3.ovf), 64'd1);
    check("d3_1000_seg", 64'(b3.seg_out), 64'({3{7'b0111111}}));
    check("d3_1000_bcd", 64'(b3.bcd_out), 64'hFFF);
    go3(65535, 1'b1);
    go3(5, 1'b1);
    check("d3_5_seg", 64'(b3.seg_out), 64'({7'b1111111, 7'b1111111, 7'b0010010}));

    check("q5_empty", 64'(q5.size()), 64'd0);
    check("q3_empty", 64'(q3.size()), 64'd0);
    check("d5_done_total", 64'(dcnt5), 64'(n_acc5 - n_drop5));
    check("d3_done_total", 64'(dcnt3), 64'(n_acc3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
